// File: rtl/main_memory_responder.sv
// main_memory_responder: clocked 64x128-bit backing store answering cache block reads and word-masked writes after LATENCY cycles
// Ports: clk/reset (sync, active-high); req/we/addr/wmask/wdata request sampled in IDLE;
//        rdata block result held until next acceptance; done one-cycle completion pulse; busy high while a request is in flight.
module main_memory_responder #(
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic [9:0]   addr,
  input  logic [3:0]   wmask,
  input  logic [127:0] wdata,
  output logic [127:0] rdata,
  output logic         done,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [5:0]     blk_q;
  logic           we_q;
  logic [3:0]     wmask_q;
  logic [127:0]   wdata_q, rdata_q, cur, nxt;
  logic [127:0]   mem_q [64];
  // Per-word "has been written" flags let never-written words read as their
  // power-up value (word i = i) without needing an initialised RAM.
  logic [255:0]   wr_q = '0;
  logic           accept, access, unused_addr;
  assign unused_addr = ^addr[3:0];
  assign accept = state_q == IDLE && req;
  assign access = state_q == WAIT && cnt_q == 4'd0;
  always_comb begin
    state_d = state_q == IDLE ? (req ? WAIT : IDLE) :
              state_q == WAIT ? (cnt_q == 4'd0 ? RESP : WAIT) : IDLE;
    cnt_d = accept ? 4'(LATENCY - 1) :
            (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  end
  always_comb begin
    cur = '0;
    nxt = '0;
    for (int w = 0; w < 4; w++) begin
      cur[32*w +: 32] = wr_q[{blk_q, w[1:0]}] ? mem_q[blk_q][32*w +: 32] : {24'd0, blk_q, w[1:0]};
      nxt[32*w +: 32] = (we_q && wmask_q[w]) ? wdata_q[32*w +: 32] : cur[32*w +: 32];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        blk_q   <= addr[9:4];
        we_q    <= we;
        wmask_q <= wmask;
        wdata_q <= wdata;
      end
      if (access) rdata_q <= nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && access && we_q) begin
      mem_q[blk_q] <= nxt;
      wr_q         <= wr_q | (256'(wmask_q) << {blk_q, 2'b00});
    end
  end
  assign rdata = rdata_q;
  assign done  = state_q == RESP;
  assign busy  = state_q != IDLE;
endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Clocked main-memory responder serving 128-bit block reads and word-masked block writes to the direct-mapped cache controller. It replaces the combinational main-memory model with a request/done handshake and a programmable access latency, so the cache can be stalled on misses and write-throughs. The block sits below the cache and owns the 1 KiB backing store: 64 blocks × 4 words × 32 bits.

## Interface
- LATENCY, 4, cycles from request acceptance to the array access edge; legal range 1..15.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  0 = block read, 1 = masked block write.
- addr  input  10  byte address; block index = addr[9:4]; addr[3:0] ignored.
- wmask  input  4  word write enables; bit w selects word w (bits [32w+31:32w]); ignored on reads.
- wdata  input  128  write block; word w at bits [32w+31:32w].
- rdata  output  128  block contents; valid while done=1, held until the next acceptance.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high from acceptance until the cycle after done.

## Operation
- Storage: 64 × 128-bit array. At time zero, word i (i = 0..255) = i, so block b word w = 4b+w. Reset does not clear the array.
- States: IDLE, WAIT, RESP. Counter cnt is 4 bits.
- IDLE: if req=1, accept the request.
  - Latch addr[9:4], we, wmask and wdata.
  - Load cnt ← LATENCY−1 and go to WAIT.
  - If req=0, remain in IDLE.
- WAIT: if cnt≠0, decrement cnt. If cnt=0, perform the access on this edge and go to RESP.
  - Read: rdata ← mem[blk].
  - Write: for each w with wmask[w]=1, replace word w of mem[blk] with wdata word w.
  - Write: rdata ← the post-write block value, so the cache can refill on a write miss.
  - Write with wmask=0000: no array change; rdata ← current block value.
- RESP: done=1 for this single cycle, then return to IDLE unconditionally.
- req is ignored in WAIT and RESP. It is not queued. A new request is accepted only in IDLE.
- Read-after-write to the same block returns the written data. The write commits at its access edge, before any later request can be accepted.
- busy = (state≠IDLE). done = (state=RESP). Both are registered-state decodes and glitch-free.

## Timing
- Reset values: state=IDLE, cnt=0, done=0, busy=0, rdata=128'h0. Latched request registers are cleared to 0.
- reset has priority over every other input on the same edge.
- Reset in WAIT aborts the request: no done, and no array write (the commit edge has not occurred).
- Reset on the RESP edge: the array write has already committed; done falls and rdata clears.
- Acceptance at edge k:
  - busy rises after edge k.
  - The array access occurs at edge k+LATENCY.
  - done is high in the cycle between edges k+LATENCY and k+LATENCY+1.
  - busy and done fall after edge k+LATENCY+1.
- Minimum spacing between acceptances is LATENCY+2 cycles. With req held high continuously, done pulses every LATENCY+2 cycles.
- With LATENCY=1, the access occurs on the edge after acceptance.
- rdata changes only on access edges and on reset.
- Inputs must be stable only at the acceptance edge. Changes to addr, wdata, wmask or we during WAIT have no effect.

## Test plan
- Read block 0, LATENCY=4: reset, then req=1, we=0, addr=10'h000 for one cycle → done high exactly 4 edges after acceptance; rdata={32'd3,32'd2,32'd1,32'd0}; busy high 5 cycles.
- Masked write: we=1, addr=10'h3A8 (block 58), wmask=4'b0100, wdata word2=32'hDEADBEEF, other words 32'hFFFFFFFF → rdata={32'd235,32'hDEADBEEF,32'd233,32'd232}. A follow-up read of 10'h3A0 returns the same value.
- Request while busy: accept a read of 10'h010, then pulse req with addr=10'h020 during WAIT → exactly one done; rdata={7,6,5,4}; no second done.
- Reset mid-operation: accept a write to 10'h050 (wmask=4'b1111, wdata=all 32'hA5A5A5A5), assert reset two cycles later → done never asserts; busy=0 and rdata=0 after reset. A later read of 10'h050 returns {23,22,21,20}.
- Back-to-back, LATENCY=1: hold req=1 and read alternating 10'h000/10'h3F0 → done every 3 cycles; rdata alternates {3,2,1,0} and {255,254,253,252}.
- Offset bits ignored: reads of 10'h01F and 10'h010 both return {7,6,5,4}. A write with wmask=4'b0000 to 10'h010 leaves block 1 unchanged and returns {7,6,5,4}.
